dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port data memory between requester 0 (CPU load/store unit) and requester 1 (DMA / debug loader).
- Sits between the requesters and the data memory.
- Issues at most one access per cycle.
- Uses round-robin priority, with an optional bus lock so a requester can perform atomic read-modify-write sequences.
- Returns read data registered, one cycle after grant.

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/dmem_lock_timer.sv | 46 ++++
 rtl/dmem_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: owner state encoding,
// port index constants, statistics counter width and a saturating helper.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int STAT_W = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] satInc(input logic [STAT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/dmem_lock_timer.sv
// Lock hold timer for the data-memory arbiter. Counts how long the current
// owner has held the bus and raises expired_o once MAX_LOCK is reached so
// the owner can be forcibly released.
module dmem_lock_timer
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic hold_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: clear on release, start at 1 on acquisition, otherwise
  // advance each owned cycle and stop at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = 8'd0;
    end else if (load_i) begin
      cnt_d = 8'd1;
    end else if (hold_i && (cnt_q < MAX_CNT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Port 0 is the CPU load/store unit, port 1 the DMA / debug loader. A
// requester may lock the bus for read-modify-write sequences; the lock
// times out after MAX_LOCK cycles. Read data returns one cycle after grant.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_LOCK = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic              p0_lock,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_p0_grants,
  output logic [STAT_W-1:0] stat_p1_grants,
  output logic [STAT_W-1:0] stat_conflicts
`endif
);

  owner_e owner_q;
  logic   lastGnt_q;

  logic              p0Rvalid_q;
  logic              p1Rvalid_q;
  logic [DATA_W-1:0] p0Rdata_q;
  logic [DATA_W-1:0] p1Rdata_q;

  logic gnt0;
  logic gnt1;
  logic ownerGnt;
  logic ownerLock;
  logic lockLoad;
  logic lockForced;
  logic lockRelease;
  logic lockHold;
  logic lockExpired;

  // Grant selection: an owner blocks the other port even when idle;
  // otherwise a tie goes to the port that was not granted last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      case (owner_q)
        OWN_NONE: begin
          if (p0_req && p1_req) begin
            if (lastGnt_q == PORT1) begin
              gnt0 = 1'b1;
            end else begin
              gnt1 = 1'b1;
            end
          end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
          end
        end
        OWN_P0:  gnt0 = p0_req;
        OWN_P1:  gnt1 = p1_req;
        default: ;
      endcase
    end
  end

  // Memory port follows whichever requester was granted; idle drives zeros.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = p0_we;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (gnt1) begin
      mem_we    = p1_we;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
  end

  // Pick out the current owner's grant and lock request.
  always_comb begin
    ownerGnt  = 1'b0;
    ownerLock = 1'b0;
    case (owner_q)
      OWN_P0: begin
        ownerGnt  = gnt0;
        ownerLock = p0_lock;
      end
      OWN_P1: begin
        ownerGnt  = gnt1;
        ownerLock = p1_lock;
      end
      default: ;
    endcase
  end

  assign lockLoad    = (owner_q == OWN_NONE) && ((gnt0 && p0_lock) || (gnt1 && p1_lock));
  assign lockForced  = (owner_q != OWN_NONE) && lockExpired;
  assign lockRelease = lockForced || ((owner_q != OWN_NONE) && ownerGnt && !ownerLock);
  assign lockHold    = (owner_q != OWN_NONE) && !lockRelease;

  dmem_lock_timer #(
    .MAX_LOCK (MAX_LOCK)
  ) u_lock_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (lockLoad),
    .hold_i    (lockHold),
    .clear_i   (lockRelease),
    .expired_o (lockExpired)
  );

  // Ownership state machine and round-robin history.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= OWN_NONE;
      lastGnt_q <= PORT1;
    end else begin
      case (owner_q)
        OWN_NONE: begin
          if (lockLoad) begin
            owner_q <= gnt0 ? OWN_P0 : OWN_P1;
          end
        end
        OWN_P0, OWN_P1: begin
          if (lockRelease) begin
            owner_q <= OWN_NONE;
          end
        end
        default: owner_q <= OWN_NONE;
      endcase
      if (gnt0) begin
        lastGnt_q <= PORT0;
      end else if (gnt1) begin
        lastGnt_q <= PORT1;
      end else if (lockForced) begin
        lastGnt_q <= (owner_q == OWN_P1) ? PORT1 : PORT0;
      end
    end
  end

  // Capture read data at the grant edge and pulse rvalid for one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      p0Rvalid_q <= 1'b0;
      p1Rvalid_q <= 1'b0;
      p0Rdata_q  <= '0;
      p1Rdata_q  <= '0;
    end else begin
      p0Rvalid_q <= gnt0 && !p0_we;
      p1Rvalid_q <= gnt1 && !p1_we;
      if (gnt0 && !p0_we) begin
        p0Rdata_q <= mem_rdata;
      end
      if (gnt1 && !p1_we) begin
        p1Rdata_q <= mem_rdata;
      end
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = p0Rvalid_q;
  assign p1_rvalid = p1Rvalid_q;
  assign p0_rdata  = p0Rdata_q;
  assign p1_rdata  = p1Rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [STAT_W-1:0] statP0_q;
  logic [STAT_W-1:0] statP1_q;
  logic [STAT_W-1:0] statConf_q;

  // Saturating usage counters; with one grant per cycle, any cycle with
  // both requests raised refuses one of them.
  always_ff @(posedge clk) begin
    if (reset) begin
      statP0_q   <= '0;
      statP1_q   <= '0;
      statConf_q <= '0;
    end else begin
      if (gnt0) begin
        statP0_q <= satInc(statP0_q);
      end
      if (gnt1) begin
        statP1_q <= satInc(statP1_q);
      end
      if (p0_req && p1_req) begin
        statConf_q <= satInc(statConf_q);
      end
    end
  end

  assign stat_p0_grants = statP0_q;
  assign stat_p1_grants = statP1_q;
  assign stat_conflicts = statConf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural memory and a
// read-data scoreboard. Builds with or without DMEM_ARB_STATS_EN.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p0_lock;
  logic [15:0] p0_addr, p0_wdata;
  logic        p0_gnt, p0_rvalid;
  logic [15:0] p0_rdata;
  logic        p1_req, p1_we, p1_lock;
  logic [15:0] p1_addr, p1_wdata;
  logic        p1_gnt, p1_rvalid;
  logic [15:0] p1_rdata;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_p0_grants, stat_p1_grants, stat_conflicts;
`endif

  typedef struct {
    logic        port;
    logic [15:0] data;
  } rdExp_t;

  rdExp_t      sbQ[$];
  logic [15:0] memArr[256];
  logic [15:0] refMem[256];
  int          testCount = 0;
  int          failCount = 0;
  int          expP0Grants = 0;
  int          expP1Grants = 0;
  int          expConflicts = 0;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .p0_req    (p0_req),
    .p0_we     (p0_we),
    .p0_addr   (p0_addr),
    .p0_wdata  (p0_wdata),
    .p0_lock   (p0_lock),
    .p0_gnt    (p0_gnt),
    .p0_rvalid (p0_rvalid),
    .p0_rdata  (p0_rdata),
    .p1_req    (p1_req),
    .p1_we     (p1_we),
    .p1_addr   (p1_addr),
    .p1_wdata  (p1_wdata),
    .p1_lock   (p1_lock),
    .p1_gnt    (p1_gnt),
    .p1_rvalid (p1_rvalid),
    .p1_rdata  (p1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stat_p0_grants (stat_p0_grants),
    .stat_p1_grants (stat_p1_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port memory: asynchronous read, write on the edge.
  assign mem_rdata = memArr[mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_we) memArr[mem_addr[7:0]] <= mem_wdata;
  end

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [15:0] a0,
                               input logic [15:0] d0, input logic l0,
                               input logic r1, input logic w1, input logic [15:0] a1,
                               input logic [15:0] d1, input logic l1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0; p0_lock = l0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_lock = l1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  // Check one cycle mid-period, update the scoreboard, then step a clock.
  task automatic checkOutput(input logic expG0, input logic expG1, input string tag);
    rdExp_t      e;
    logic        expWe;
    logic [15:0] expAddr;
    logic [15:0] expWdata;
    @(negedge clk);
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      if (e.port == 1'b0) begin
        compare({tag, "_rvalid0"}, 32'(p0_rvalid), 32'd1);
        compare({tag, "_rdata0"},  32'(p0_rdata),  32'(e.data));
        compare({tag, "_rvalid1"}, 32'(p1_rvalid), 32'd0);
      end else begin
        compare({tag, "_rvalid1"}, 32'(p1_rvalid), 32'd1);
        compare({tag, "_rdata1"},  32'(p1_rdata),  32'(e.data));
        compare({tag, "_rvalid0"}, 32'(p0_rvalid), 32'd0);
      end
    end else begin
      compare({tag, "_rvalid0"}, 32'(p0_rvalid), 32'd0);
      compare({tag, "_rvalid1"}, 32'(p1_rvalid), 32'd0);
    end
    compare({tag, "_gnt0"}, 32'(p0_gnt), 32'(expG0));
    compare({tag, "_gnt1"}, 32'(p1_gnt), 32'(expG1));
    expWe = 1'b0; expAddr = 16'h0; expWdata = 16'h0;
    if (expG0) begin
      expWe = p0_we; expAddr = p0_addr; expWdata = p0_wdata;
    end else if (expG1) begin
      expWe = p1_we; expAddr = p1_addr; expWdata = p1_wdata;
    end
    compare({tag, "_mem_we"},    32'(mem_we),    32'(expWe));
    compare({tag, "_mem_addr"},  32'(mem_addr),  32'(expAddr));
    compare({tag, "_mem_wdata"}, 32'(mem_wdata), 32'(expWdata));
`ifdef DMEM_ARB_STATS_EN
    compare({tag, "_stat_p0"},   32'(stat_p0_grants), 32'(16'(expP0Grants)));
    compare({tag, "_stat_p1"},   32'(stat_p1_grants), 32'(16'(expP1Grants)));
    compare({tag, "_stat_conf"}, 32'(stat_conflicts), 32'(16'(expConflicts)));
`endif
    if (expG0 && !p0_we) sbQ.push_back('{1'b0, refMem[p0_addr[7:0]]});
    if (expG0 && p0_we)  refMem[p0_addr[7:0]] = p0_wdata;
    if (expG1 && !p1_we) sbQ.push_back('{1'b1, refMem[p1_addr[7:0]]});
    if (expG1 && p1_we)  refMem[p1_addr[7:0]] = p1_wdata;
    if (reset) begin
      expP0Grants = 0; expP1Grants = 0; expConflicts = 0;
    end else begin
      if (expG0) expP0Grants++;
      if (expG1) expP1Grants++;
      if (p0_req && p1_req) expConflicts++;
    end
    @(posedge clk);
    #1;
  endtask

  // Directed sequence covering reset, round-robin, write/read ordering,
  // locked sequences, forced lock release and reset during a lock.
  initial begin
    for (int i = 0; i < 256; i++) begin
      memArr[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
      refMem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
    end
    memArr[8'h10] = 16'h1234;
    refMem[8'h10] = 16'h1234;

    reset = 1'b1;
    applyStimulus(1, 0, 16'h10, 16'h0, 0, 1, 1, 16'h22, 16'h9999, 0);
    checkOutput(0, 0, "rst0");
    checkOutput(0, 0, "rst1");
    reset = 1'b0;
    compare("rst_rdata0", 32'(p0_rdata), 32'd0);
    compare("rst_rdata1", 32'(p1_rdata), 32'd0);

    applyStimulus(1, 0, 16'h10, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
    checkOutput(1, 0, "rd10");
    idle();
    checkOutput(0, 0, "rd10_ret");

    reset = 1'b1;
    checkOutput(0, 0, "rst2");
    reset = 1'b0;
    applyStimulus(1, 0, 16'h40, 16'h0, 0, 1, 0, 16'h41, 16'h0, 0);
    checkOutput(1, 0, "alt0");
    checkOutput(0, 1, "alt1");
    checkOutput(1, 0, "alt2");
    checkOutput(0, 1, "alt3");
    idle();
    checkOutput(0, 0, "alt_drain");

    applyStimulus(0, 0, 16'h0, 16'h0, 0, 1, 1, 16'h20, 16'hBEEF, 0);
    checkOutput(0, 1, "wr20");
    applyStimulus(1, 0, 16'h20, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
    checkOutput(1, 0, "rd20");
    idle();
    checkOutput(0, 0, "rd20_ret");

    applyStimulus(0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h31, 16'h0, 0);
    checkOutput(0, 1, "p1_pre");
    applyStimulus(1, 0, 16'h30, 16'h0, 1, 1, 0, 16'h31, 16'h0, 0);
    checkOutput(1, 0, "lk_rd");
    applyStimulus(1, 1, 16'h30, 16'hCAFE, 1, 1, 0, 16'h31, 16'h0, 0);
    checkOutput(1, 0, "lk_wr");
    applyStimulus(1, 0, 16'h30, 16'h0, 0, 1, 0, 16'h31, 16'h0, 0);
    checkOutput(1, 0, "lk_end");
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h31, 16'h0, 0);
    checkOutput(0, 1, "lk_p1");
    idle();
    checkOutput(0, 0, "lk_drain");

    applyStimulus(1, 0, 16'h50, 16'h0, 1, 1, 0, 16'h51, 16'h0, 1);
    checkOutput(1, 0, "fr_take");
    applyStimulus(0, 0, 16'h0, 16'h0, 0, 1, 0, 16'h51, 16'h0, 1);
    for (int i = 0; i < 8; i++) checkOutput(0, 0, "fr_wait");
    checkOutput(0, 1, "fr_p1");

    reset = 1'b1;
    applyStimulus(1, 0, 16'h52, 16'h0, 0, 1, 0, 16'h51, 16'h0, 1);
    checkOutput(0, 0, "rst_lock");
    reset = 1'b0;
    checkOutput(1, 0, "post_rst");
    idle();
    checkOutput(0, 0, "final");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
